// File: rtl/cap_pkg.sv
// rtl/cap_pkg.sv - shared states, defaults and next-set-bit search for the capture scheduler
package cap_pkg;

  localparam int CAP_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } cap_state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } cap_next_t;

  // Lowest set bit at or above position 'from'; from=0 is the search-from-minus-one case.
  function automatic cap_next_t cap_find_next(input logic [31:0] mask, input logic [5:0] from);
    cap_next_t r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cap_scheduler_if.sv
// rtl/cap_scheduler_if.sv - host/config and probe-drive bundle; trig_out exists only with CAP_SCHED_TRIG_EN
interface cap_scheduler_if #(
  parameter int NUM_CAP = 4,
  parameter int CNT_W   = cap_pkg::CAP_CNT_W_DEF
);
  localparam int IDX_W = (NUM_CAP > 1) ? $clog2(NUM_CAP) : 1;

  logic               start;
  logic               abort;
  logic [NUM_CAP-1:0] cfg_mask;
  logic [CNT_W-1:0]   cfg_high;
  logic [CNT_W-1:0]   cfg_low;
  logic [CNT_W-1:0]   cfg_repeat;
  logic [NUM_CAP-1:0] probe_out;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   cur_idx;
`ifdef CAP_SCHED_TRIG_EN
  logic               trig_out;

  modport master (output start, abort, cfg_mask, cfg_high, cfg_low, cfg_repeat,
                  input  probe_out, busy, done, cur_idx, trig_out);
  modport slave  (input  start, abort, cfg_mask, cfg_high, cfg_low, cfg_repeat,
                  output probe_out, busy, done, cur_idx, trig_out);
`else
  modport master (output start, abort, cfg_mask, cfg_high, cfg_low, cfg_repeat,
                  input  probe_out, busy, done, cur_idx);
  modport slave  (input  start, abort, cfg_mask, cfg_high, cfg_low, cfg_repeat,
                  output probe_out, busy, done, cur_idx);
`endif
endinterface

// File: rtl/cap_next_idx.sv
// rtl/cap_next_idx.sv - combinational finder for the next enabled cell above the current index
module cap_next_idx
  import cap_pkg::*;
#(
  parameter int NUM_CAP = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_CAP-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_from_start,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [31:0] w_mask32;
  logic [5:0]  w_from;

  assign w_mask32 = 32'(i_mask);
  assign w_from   = i_from_start ? 6'd0 : (6'(i_idx) + 6'd1);

  assign o_found = cap_find_next(w_mask32, w_from).found;
  assign o_idx   = IDX_W'(cap_find_next(w_mask32, w_from).idx);

endmodule

// File: rtl/cap_scheduler.sv
// rtl/cap_scheduler.sv - pulse-train scheduler over masked capture cells; CAP_SCHED_TRIG_EN adds trig_out
module cap_scheduler
  import cap_pkg::*;
#(
  parameter int NUM_CAP = 4,
  parameter int CNT_W   = CAP_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  cap_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_CAP > 1) ? $clog2(NUM_CAP) : 1;

  cap_state_t         r_state;
  logic [NUM_CAP-1:0] r_probe;
  logic               r_busy;
  logic               r_done;
  logic [IDX_W-1:0]   r_cur_idx;
  logic [NUM_CAP-1:0] r_mask;
  logic [CNT_W-1:0]   r_h_m1, r_l_m1, r_r_m1;
  logic [CNT_W-1:0]   r_cnt, r_rep;
`ifdef CAP_SCHED_TRIG_EN
  logic               r_trig;
`endif

  logic [IDX_W-1:0]   w_first_idx, w_next_idx;
  logic               w_first_found, w_next_found;

  cap_next_idx #(.NUM_CAP(NUM_CAP), .IDX_W(IDX_W)) u_first (
    .i_mask(bus.cfg_mask), .i_idx('0), .i_from_start(1'b1),
    .o_idx(w_first_idx), .o_found(w_first_found)
  );

  cap_next_idx #(.NUM_CAP(NUM_CAP), .IDX_W(IDX_W)) u_next (
    .i_mask(r_mask), .i_idx(r_cur_idx), .i_from_start(1'b0),
    .o_idx(w_next_idx), .o_found(w_next_found)
  );

  // Zero-valued config fields behave as 1, so the terminal count is max(v,1)-1.
  function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [NUM_CAP-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_CAP'(1) << i;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_probe   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cur_idx <= '0;
      r_mask    <= '0;
      r_h_m1    <= '0;
      r_l_m1    <= '0;
      r_r_m1    <= '0;
      r_cnt     <= '0;
      r_rep     <= '0;
`ifdef CAP_SCHED_TRIG_EN
      r_trig    <= 1'b0;
`endif
    end else if (bus.abort && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
      r_probe <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_rep   <= '0;
`ifdef CAP_SCHED_TRIG_EN
      r_trig  <= 1'b0;
`endif
    end else begin
`ifdef CAP_SCHED_TRIG_EN
      r_trig <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_mask <= bus.cfg_mask;
            r_h_m1 <= eff_m1(bus.cfg_high);
            r_l_m1 <= eff_m1(bus.cfg_low);
            r_r_m1 <= eff_m1(bus.cfg_repeat);
            r_cnt  <= '0;
            r_rep  <= '0;
            r_busy <= 1'b1;
            if (w_first_found) begin
              r_state   <= ST_HIGH;
              r_cur_idx <= w_first_idx;
              r_probe   <= onehot(w_first_idx);
`ifdef CAP_SCHED_TRIG_EN
              r_trig    <= 1'b1;
`endif
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (r_cnt == r_h_m1) begin
            r_cnt   <= '0;
            r_probe <= '0;
            r_state <= ST_LOW;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (r_cnt == r_l_m1) begin
            r_cnt <= '0;
            if (r_rep != r_r_m1) begin
              r_rep   <= r_rep + CNT_W'(1);
              r_state <= ST_HIGH;
              r_probe <= onehot(r_cur_idx);
`ifdef CAP_SCHED_TRIG_EN
              r_trig  <= 1'b1;
`endif
            end else if (w_next_found) begin
              r_rep     <= '0;
              r_cur_idx <= w_next_idx;
              r_state   <= ST_HIGH;
              r_probe   <= onehot(w_next_idx);
`ifdef CAP_SCHED_TRIG_EN
              r_trig    <= 1'b1;
`endif
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.probe_out = r_probe;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cur_idx   = r_cur_idx;
`ifdef CAP_SCHED_TRIG_EN
  assign bus.trig_out  = r_trig;
`endif

endmodule

// File: tb/tb_cap_scheduler.sv
// tb/tb_cap_scheduler.sv - directed self-checking bench for cap_scheduler
module tb_cap_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cap_scheduler_if #(.NUM_CAP(4), .CNT_W(16)) bus ();

  cap_scheduler #(.NUM_CAP(4), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] m, input logic [15:0] h, input logic [15:0] l, input logic [15:0] r);
    bus.cfg_mask   = m;
    bus.cfg_high   = h;
    bus.cfg_low    = l;
    bus.cfg_repeat = r;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    logic [3:0] ep;
`ifdef CAP_SCHED_TRIG_EN
    int trig_cnt;
    trig_cnt = 0;
`endif
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.cfg_mask   = '0;
    bus.cfg_high   = '0;
    bus.cfg_low    = '0;
    bus.cfg_repeat = '0;
    tick();
    tick();
    chk("rst_probe", 32'(bus.probe_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_idx", 32'(bus.cur_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic run: cells 0 and 2, H=2 L=3 R=2 -> 21 busy cycles
    go(4'b0101, 16'd2, 16'd3, 16'd2);
    for (int k = 1; k <= 22; k++) begin
      ep = (k == 1 || k == 2 || k == 6 || k == 7) ? 4'b0001 :
           (k == 11 || k == 12 || k == 16 || k == 17) ? 4'b0100 : 4'b0000;
      chk($sformatf("basic_probe_k%0d", k), 32'(bus.probe_out), 32'(ep));
      chk($sformatf("basic_busy_k%0d", k), 32'(bus.busy), 32'(k <= 21));
      chk($sformatf("basic_done_k%0d", k), 32'(bus.done), 32'(k == 21));
      if (k == 1)  chk("basic_idx_first", 32'(bus.cur_idx), 32'd0);
      if (k == 11) chk("basic_idx_second", 32'(bus.cur_idx), 32'd2);
`ifdef CAP_SCHED_TRIG_EN
      chk($sformatf("basic_trig_k%0d", k), 32'(bus.trig_out),
          32'(k == 1 || k == 6 || k == 11 || k == 16));
      if (bus.trig_out) trig_cnt++;
`endif
      if (k < 22) tick();
    end
    chk("basic_idx_hold", 32'(bus.cur_idx), 32'd2);
`ifdef CAP_SCHED_TRIG_EN
    chk("basic_trig_count", 32'(trig_cnt), 32'd4);
`endif

    // Zero config acts as H=L=R=1
    go(4'b1000, 16'd0, 16'd0, 16'd0);
    chk("zero_probe_k1", 32'(bus.probe_out), 32'b1000);
    chk("zero_idx_k1", 32'(bus.cur_idx), 32'd3);
    tick();
    chk("zero_probe_k2", 32'(bus.probe_out), 32'd0);
    chk("zero_done_k2", 32'(bus.done), 32'd0);
    tick();
    chk("zero_done_k3", 32'(bus.done), 32'd1);
    chk("zero_busy_k3", 32'(bus.busy), 32'd1);
    tick();
    chk("zero_busy_k4", 32'(bus.busy), 32'd0);

    // Empty mask: single DONE cycle
    go(4'b0000, 16'd5, 16'd5, 16'd5);
    chk("empty_done_k1", 32'(bus.done), 32'd1);
    chk("empty_busy_k1", 32'(bus.busy), 32'd1);
    chk("empty_probe_k1", 32'(bus.probe_out), 32'd0);
    tick();
    chk("empty_done_k2", 32'(bus.done), 32'd0);
    chk("empty_busy_k2", 32'(bus.busy), 32'd0);

    // Abort mid-HIGH of cell 1
    go(4'b0110, 16'd3, 16'd2, 16'd1);
    chk("abort_probe_k1", 32'(bus.probe_out), 32'b0010);
    chk("abort_idx_k1", 32'(bus.cur_idx), 32'd1);
    tick();
    chk("abort_probe_k2", 32'(bus.probe_out), 32'b0010);
    bus.abort = 1'b1;
    tick();
    chk("abort_probe_after", 32'(bus.probe_out), 32'd0);
    chk("abort_busy_after", 32'(bus.busy), 32'd0);
    chk("abort_done_after", 32'(bus.done), 32'd0);
    bus.abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", k), 32'(bus.done), 32'd0);
      chk($sformatf("abort_idle_%0d", k), 32'(bus.busy), 32'd0);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("startabort_busy", 32'(bus.busy), 32'd0);
    chk("startabort_probe", 32'(bus.probe_out), 32'd0);
    go(4'b0110, 16'd1, 16'd1, 16'd1);
    for (int k = 1; k <= 6; k++) begin
      ep = (k == 1) ? 4'b0010 : (k == 3) ? 4'b0100 : 4'b0000;
      chk($sformatf("rerun_probe_k%0d", k), 32'(bus.probe_out), 32'(ep));
      chk($sformatf("rerun_done_k%0d", k), 32'(bus.done), 32'(k == 5));
      chk($sformatf("rerun_busy_k%0d", k), 32'(bus.busy), 32'(k <= 5));
      if (k < 6) tick();
    end

    // start while busy (and in DONE) with changed config is ignored
    go(4'b0001, 16'd2, 16'd2, 16'd1);
    chk("ign_probe_k1", 32'(bus.probe_out), 32'b0001);
    tick();
    chk("ign_probe_k2", 32'(bus.probe_out), 32'b0001);
    bus.start    = 1'b1;
    bus.cfg_high = 16'd5;
    bus.cfg_mask = 4'b1000;
    tick();
    bus.start = 1'b0;
    chk("ign_probe_k3", 32'(bus.probe_out), 32'd0);
    chk("ign_busy_k3", 32'(bus.busy), 32'd1);
    tick();
    chk("ign_probe_k4", 32'(bus.probe_out), 32'd0);
    chk("ign_done_k4", 32'(bus.done), 32'd0);
    tick();
    chk("ign_done_k5", 32'(bus.done), 32'd1);
    chk("ign_probe_k5", 32'(bus.probe_out), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_busy_k6", 32'(bus.busy), 32'd0);
    chk("ign_done_k6", 32'(bus.done), 32'd0);
    chk("ign_probe_k6", 32'(bus.probe_out), 32'd0);
    tick();
    chk("ign_busy_k7", 32'(bus.busy), 32'd0);
    chk("ign_done_k7", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-LOW
    go(4'b0100, 16'd2, 16'd4, 16'd1);
    chk("arst_probe_k1", 32'(bus.probe_out), 32'b0100);
    tick();
    tick();
    tick();
    chk("arst_probe_k4", 32'(bus.probe_out), 32'd0);
    chk("arst_busy_k4", 32'(bus.busy), 32'd1);
    chk("arst_idx_k4", 32'(bus.cur_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy_now", 32'(bus.busy), 32'd0);
    chk("arst_idx_now", 32'(bus.cur_idx), 32'd0);
    chk("arst_done_now", 32'(bus.done), 32'd0);
    chk("arst_probe_now", 32'(bus.probe_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_busy_after", 32'(bus.busy), 32'd0);
    chk("arst_probe_after", 32'(bus.probe_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cap_scheduler.md
Name: cap_scheduler

Overview:
- Sequences an array of NUM_CAP probe-capture cells by driving each cell's probe input with a programmed pulse train.
- Shares the probe-excitation resource between cells one at a time, in ascending index order, restricted to the cells enabled in a mask.
- Sits between the host/config logic and the capture-cell array; one probe_out bit drives each cell's probe_signal.
- Start/busy/done handshake; abort supported.

Parameters:
- NUM_CAP, 4, number of capture cells scheduled (1..32).
- CNT_W, 16, width of the period and repeat counters and config fields.
- IDX_W, $clog2(NUM_CAP) (min 1), width of cur_idx; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; forces return to IDLE.
- cfg_mask  in  NUM_CAP  cell enable mask; bit i=1 schedules cell i.
- cfg_high  in  CNT_W  pulse high duration in cycles.
- cfg_low  in  CNT_W  pulse low duration in cycles.
- cfg_repeat  in  CNT_W  pulses per cell.
- probe_out  out  NUM_CAP  registered drive to each cell's probe_signal; at most one bit set.
- busy  out  1  registered; high whenever state != IDLE.
- done  out  1  registered one-cycle completion pulse.
- cur_idx  out  IDX_W  index of the cell currently driven.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: probe_out=0, busy=0, done=0, cur_idx=0, state=IDLE, all counters 0.
- Effective values: H=max(cfg_high,1), L=max(cfg_low,1), R=max(cfg_repeat,1).
- Config latching: cfg_* are captured on the accepting start edge. Later changes have no effect until the next start.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - If start=1 and abort=0 and latched mask!=0: go to HIGH on the next edge, with cur_idx = lowest set bit of mask and probe_out = one-hot(cur_idx).
  - If mask==0: go to DONE directly; no probe activity.
- HIGH: probe_out[cur_idx]=1 for exactly H cycles, then LOW.
- LOW: probe_out=0 for exactly L cycles. On the last LOW cycle:
  - pulses sent to this cell < R: go to HIGH, same cell.
  - else, a higher set mask bit remains: go to HIGH with cur_idx = next set bit. No idle gap; next pulse starts the cycle after the last LOW cycle.
  - else: go to DONE.
- DONE: done=1 for one cycle, busy=1; then IDLE. cur_idx holds its last value in IDLE.
- Latency: start accepted at edge T → probe high from T+1. Total busy length for k enabled cells = k·R·(H+L)+1 cycles; mask==0 gives 1 cycle.
- start while busy: ignored, including start in DONE.
- start and abort in the same IDLE cycle: abort wins; nothing starts.
- abort in HIGH/LOW/DONE: on the next edge go to IDLE with probe_out=0, busy=0, done=0; no done pulse. A done already showing in the DONE cycle is not extended.
- Counters saturate at no point; compare against H−1/L−1/R−1 at CNT_W width. cfg=all-ones is legal (2^CNT_W−1 cycles).
- Async reset mid-operation: all outputs take reset values immediately.

Optional Feature:
- Macro: CAP_SCHED_TRIG_EN.
- Defined:
  - adds output trig_out (1 bit, reset 0).
  - trig_out is a registered one-cycle pulse coincident with the first cycle of every HIGH phase.
  - intended to arm external scope/measurement logic.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package cap_pkg holds:
  - state enum/localparams (ST_IDLE=2'd0, ST_HIGH=2'd1, ST_LOW=2'd2, ST_DONE=2'd3).
  - default CNT_W.
  - function for the lowest-set-bit-above-index search.
- One natural sub-module: cap_next_idx, a combinational priority finder. Inputs are mask and current index; outputs are next index and a found flag. It is used both for the first-cell pick (search from −1) and for advancing.
- Counters and FSM stay in cap_scheduler.

Test Plan:
- Basic run:
  - Stimulus: mask=4'b0101, H=2, L=3, R=2; start at T.
  - Response: probe_out[0] high T+1..T+2, T+6..T+7; probe_out[2] high T+11..T+12, T+16..T+17; done at T+21; busy T+1..T+21.
- Zero config:
  - Stimulus: H=0, L=0, R=0, mask=4'b1000.
  - Response: probe_out[3] high exactly one cycle, low one cycle; done at T+3.
- Empty mask:
  - Stimulus: mask=0, start.
  - Response: done pulse at T+1; probe_out stays 0; busy high one cycle.
- Abort:
  - Stimulus: abort asserted mid-HIGH of cell 1.
  - Response: next edge probe_out=0, busy=0; no done pulse. A new start afterwards runs the full sequence from the lowest set bit.
- Ignored start / config change:
  - Stimulus: start pulsed while busy, with cfg_high changed.
  - Response: sequence timing unchanged; no restart; single done.
- Async reset:
  - Stimulus: rst_n low mid-LOW.
  - Response: all outputs 0 immediately, before any clock edge.
  - With CAP_SCHED_TRIG_EN: trig_out pulses once per HIGH entry (4 pulses in the basic-run test).
